// File: rtl/act_sram_streamer_pkg.sv
// Types and default widths shared between the activation streamer and the row routers.
package router_pkg;

    localparam int DEFAULT_SRAM_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH      = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN
    } streamer_state_t;

endpackage

// File: rtl/act_sram_streamer_if.sv
// Control, SRAM and broadcast bundle between the streamer (master) and its surroundings (slave).
interface act_sram_streamer_if #(
    parameter int SRAM_DATA_WIDTH = router_pkg::DEFAULT_SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = router_pkg::DEFAULT_ADDR_WIDTH,
    parameter int ROUTER_COUNT    = 8,
    parameter int MAX_PASSES      = 4
);
    import router_pkg::*;

    localparam int PASS_W = $clog2(MAX_PASSES + 1);

    logic                       i_start;
    logic                       i_abort;
    logic                       i_hold;
    logic [ADDR_WIDTH-1:0]      i_start_addr;
    logic [ADDR_WIDTH:0]        i_word_count;
    logic [ROUTER_COUNT-1:0]    i_mpp_empty;
    logic                       o_sram_ren;
    logic [ADDR_WIDTH-1:0]      o_sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] i_sram_rdata;
    logic                       o_ag_en;
    logic                       o_ac_en;
    // o_data_valid qualifies o_data/o_addr for exactly one cycle with no ready;
    // the only backpressure is i_hold, which stops new reads but never in-flight returns.
    logic [SRAM_DATA_WIDTH-1:0] o_data;
    logic [ADDR_WIDTH-1:0]      o_addr;
    logic                       o_data_valid;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_error;
    logic [PASS_W-1:0]          o_pass_count;
    streamer_state_t            state;

    modport master (
        input  i_start, i_abort, i_hold, i_start_addr, i_word_count, i_mpp_empty, i_sram_rdata,
        output o_sram_ren, o_sram_addr, o_ag_en, o_ac_en, o_data, o_addr, o_data_valid,
        output o_busy, o_done, o_error, o_pass_count, state
    );

    modport slave (
        output i_start, i_abort, i_hold, i_start_addr, i_word_count, i_mpp_empty, i_sram_rdata,
        input  o_sram_ren, o_sram_addr, o_ag_en, o_ac_en, o_data, o_addr, o_data_valid,
        input  o_busy, o_done, o_error, o_pass_count, state
    );

endinterface

// File: rtl/act_sram_streamer_read_pipe.sv
// Delays {read-enable, address} by the SRAM read latency so each return is tagged with its address.
module sram_read_pipe #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  tail_valid,
    output logic [ADDR_WIDTH-1:0] tail_addr,
    output logic                  busy
);
    logic [LATENCY-1:0]    valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [LATENCY];

    always_ff @(posedge clk) begin
        if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) addr_q[i] <= '0;
        end else begin
            valid_q[0] <= ren;
            addr_q[0]  <= addr;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign tail_valid = valid_q[LATENCY-1];
    assign tail_addr  = addr_q[LATENCY-1];
    assign busy       = |valid_q;

endmodule

// File: rtl/act_sram_streamer.sv
// Arms the row routers, sweeps the activation SRAM and broadcasts each word,
// re-sweeping until every router MPP FIFO is empty or the pass budget runs out.
module act_sram_streamer
    import router_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = DEFAULT_SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int ROUTER_COUNT    = 8,
    parameter int SRAM_LATENCY    = 1,
    parameter int MAX_PASSES      = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    act_sram_streamer_if.master bus
);
    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    localparam int CNT_W  = ADDR_WIDTH + 1;

    streamer_state_t         state_q;
    logic [ADDR_WIDTH-1:0]   start_addr_q, cur_q, tail_addr;
    logic [CNT_W-1:0]        word_count_q, issued_q;
    logic [PASS_W-1:0]       pass_q, pass_next;
    logic                    ag_en_q, ac_en_q, busy_q, done_q, error_q;
    logic                    kill, ren, last_issue, all_empty, tail_valid, pipe_busy;
    logic [ROUTER_COUNT-1:0] mpp_empty;

    assign kill       = i_rst | bus.i_abort;
    assign mpp_empty  = bus.i_mpp_empty;
    assign all_empty  = &mpp_empty;
    assign pass_next  = pass_q + PASS_W'(1);
    assign ren        = (state_q == STREAM) && !bus.i_hold && (issued_q != word_count_q);
    // Leave STREAM on the edge that issues the last read so DRAIN starts with it in flight.
    assign last_issue = ren && (issued_q + CNT_W'(1) == word_count_q);

    sram_read_pipe #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (SRAM_LATENCY)
    ) u_read_pipe (
        .clk       (i_clk),
        .flush     (kill),
        .ren       (ren),
        .addr      (cur_q),
        .tail_valid(tail_valid),
        .tail_addr (tail_addr),
        .busy      (pipe_busy)
    );

    always_ff @(posedge i_clk) begin
        if (kill) begin
            state_q      <= IDLE;
            start_addr_q <= '0;
            cur_q        <= '0;
            word_count_q <= '0;
            issued_q     <= '0;
            pass_q       <= '0;
            ag_en_q      <= 1'b0;
            ac_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            ag_en_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        start_addr_q <= bus.i_start_addr;
                        word_count_q <= bus.i_word_count;
                        pass_q       <= '0;
                        ag_en_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ARM;
                    end
                end
                ARM: begin
                    cur_q    <= start_addr_q;
                    issued_q <= '0;
                    ac_en_q  <= 1'b1;
                    state_q  <= STREAM;
                end
                STREAM: begin
                    if (ren) begin
                        cur_q    <= cur_q + ADDR_WIDTH'(1);
                        issued_q <= issued_q + CNT_W'(1);
                    end
                    if (issued_q == word_count_q || last_issue) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The first empty-pipe cycle is the settle cycle: the last pop has landed.
                    if (!pipe_busy) begin
                        pass_q <= pass_next;
                        if (all_empty || pass_next == PASS_W'(MAX_PASSES)) begin
                            done_q  <= all_empty;
                            error_q <= !all_empty;
                            busy_q  <= 1'b0;
                            ac_en_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cur_q    <= start_addr_q;
                            issued_q <= '0;
                            state_q  <= STREAM;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ac_en_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sram_ren   = ren;
    assign bus.o_sram_addr  = cur_q;
    assign bus.o_ag_en      = ag_en_q;
    assign bus.o_ac_en      = ac_en_q;
    assign bus.o_data_valid = tail_valid;
    assign bus.o_addr       = tail_valid ? tail_addr : '0;
    assign bus.o_data       = tail_valid ? bus.i_sram_rdata : '0;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;
    assign bus.o_pass_count = pass_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_act_sram_streamer.sv
// Randomized and directed jobs for act_sram_streamer, checked against a sweep-level reference model.
module tb_act_sram_streamer;
    import router_pkg::*;

    localparam int DW   = 64;
    localparam int AW   = 8;
    localparam int RC   = 8;
    localparam int LAT  = 1;
    localparam int MAXP = 4;

    logic clk;
    logic rst;

    act_sram_streamer_if #(
        .SRAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROUTER_COUNT(RC), .MAX_PASSES(MAXP)
    ) bus ();

    act_sram_streamer #(
        .SRAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROUTER_COUNT(RC),
        .SRAM_LATENCY(LAT), .MAX_PASSES(MAXP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    logic [DW-1:0] mem [256];
    logic [AW-1:0] exp_q[$];
    int            n_checks, n_fail, cyc;
    bit            mon_en, valid_in_hold;
    int            n_ren, n_done, n_err, n_ag, ag_cycle, done_cycle, first_ren, last_ren;
    int            k_all;
    logic [RC-1:0] partial;
    logic          prev_ren;
    logic [AW-1:0] prev_addr;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SRAM: one-cycle read latency from ren to rdata.
    initial begin
        bus.i_sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.o_sram_ren) bus.i_sram_rdata <= mem[bus.o_sram_addr];
        end
    end

    // Routers report all-empty from sweep number k_all onwards.
    always_comb begin
        bus.i_mpp_empty = partial;
        if (int'(bus.o_pass_count) >= k_all - 1) bus.i_mpp_empty = '1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ren"},        bus.o_sram_ren, 0);
        check({tag, "_sram_addr"},  bus.o_sram_addr, 0);
        check({tag, "_ag_en"},      bus.o_ag_en, 0);
        check({tag, "_ac_en"},      bus.o_ac_en, 0);
        check({tag, "_data"},       bus.o_data, 0);
        check({tag, "_addr"},       bus.o_addr, 0);
        check({tag, "_valid"},      bus.o_data_valid, 0);
        check({tag, "_busy"},       bus.o_busy, 0);
        check({tag, "_done"},       bus.o_done, 0);
        check({tag, "_error"},      bus.o_error, 0);
        check({tag, "_pass_count"}, bus.o_pass_count, 0);
        check({tag, "_state"},      bus.state, IDLE);
    endtask

    // Scoreboard: reads must follow exp_q; every broadcast is the word read one cycle earlier.
    initial begin
        prev_ren  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.o_sram_ren) begin
                    check("ren_ac_en", bus.o_ac_en, 1);
                    if (exp_q.size() == 0) check("ren_extra", 1, 0);
                    else check("ren_addr", bus.o_sram_addr, exp_q.pop_front());
                    if (n_ren == 0) first_ren = cyc;
                    last_ren = cyc;
                    n_ren++;
                end
                check("valid_latency", bus.o_data_valid, prev_ren);
                if (bus.o_data_valid) begin
                    check("bcast_addr", bus.o_addr, prev_addr);
                    check("bcast_data", bus.o_data, mem[prev_addr]);
                    if (bus.i_hold) valid_in_hold = 1'b1;
                end
                if (bus.o_ag_en) begin
                    n_ag++;
                    ag_cycle = cyc;
                end
                if (bus.o_done) begin
                    n_done++;
                    done_cycle = cyc;
                end
                if (bus.o_error) n_err++;
            end
            prev_ren  = mon_en && bus.o_sram_ren;
            prev_addr = bus.o_sram_addr;
        end
    end

    // ---------------- driver tasks ----------------
    // hold_mode: 0 none, 1 random, 2 three cycles right after the 4th read.
    task automatic run_job(input logic [AW-1:0] sa, input logic [AW:0] cnt, input int k,
                           input logic [RC-1:0] part, input int hold_mode, input bit inject);
        int passes, hold_left, after;
        bit exp_ok, hold_done, finished;
        passes = (k <= MAXP) ? k : MAXP;
        exp_ok = (k <= MAXP);
        exp_q.delete();
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < int'(cnt); i++) exp_q.push_back(sa + AW'(i));
        n_ren = 0; n_done = 0; n_err = 0; n_ag = 0;
        ag_cycle = 0; done_cycle = 0; first_ren = 0; last_ren = 0;
        valid_in_hold = 1'b0;
        k_all = k;
        partial = part;
        hold_left = 0; hold_done = 1'b0; after = 0; finished = 1'b0;

        bus.i_start_addr = sa;
        bus.i_word_count = cnt;
        bus.i_start      = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int c = 0; c < 2000 && after < 4; c++) begin
            bus.i_hold = 1'b0;
            if (hold_mode == 1) bus.i_hold = ($urandom_range(0, 2) == 0);
            if (hold_mode == 2) begin
                if (hold_left > 0) begin
                    bus.i_hold = 1'b1;
                    hold_left--;
                    if (hold_left == 0) hold_done = 1'b1;
                end else if (!hold_done && n_ren == 4) begin
                    bus.i_hold = 1'b1;
                    hold_left  = 2;
                end
            end
            bus.i_start = 1'b0;
            if (inject && c == 3) begin
                bus.i_start      = 1'b1;
                bus.i_start_addr = 8'h80;
                bus.i_word_count = 9'd3;
            end
            @(posedge clk); #1;
            if (n_done + n_err > 0) begin
                finished = 1'b1;
                after++;
            end
        end
        bus.i_hold  = 1'b0;
        bus.i_start = 1'b0;

        check("job_timeout", finished, 1);
        check("reads_left", exp_q.size(), 0);
        check("read_count", n_ren, passes * int'(cnt));
        check("done_pulses", n_done, exp_ok);
        check("error_pulses", n_err, !exp_ok);
        check("pass_count", bus.o_pass_count, passes);
        check("ag_en_cycles", n_ag, 1);
        check("busy_after", bus.o_busy, 0);
        // Single unheld sweep: reads start right after ARM, run back to back, and
        // done follows the last return plus one settle cycle (count=0: ARM, STREAM, DRAIN).
        if (hold_mode == 0 && passes == 1 && exp_ok) begin
            check("done_latency", done_cycle - ag_cycle, int'(cnt) + 3);
            if (cnt != 0) begin
                check("first_read", first_ren - ag_cycle, 1);
                check("read_burst", last_ren - first_ren, int'(cnt) - 1);
            end
        end
        if (hold_mode == 2) check("bcast_in_hold", valid_in_hold, 1);
    endtask

    task automatic kill_mid_job(input bit use_abort);
        mon_en = 1'b0;
        k_all = 1;
        partial = '1;
        bus.i_start_addr = 8'h40;
        bus.i_word_count = 9'd20;
        bus.i_start      = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if (use_abort) bus.i_abort = 1'b1;
        else rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_abort = 1'b0;
        @(negedge clk);
        check_idle(use_abort ? "abort_mid" : "rst_mid");
        @(posedge clk); #1;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        k_all    = 1;
        partial  = '1;
        rst      = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_hold       = 1'b0;
        bus.i_start_addr = '0;
        bus.i_word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        kill_mid_job(1'b0);
        run_job(8'h10, 9'd9, 1, '1, 0, 1'b0);
        run_job(8'h10, 9'd9, 1, '1, 2, 1'b1);
        run_job(8'hFE, 9'd4, 1, '1, 0, 1'b0);
        run_job(8'h20, 9'd5, 5, 8'hFE, 0, 1'b0);
        run_job(8'h33, 9'd0, 1, '1, 0, 1'b0);
        kill_mid_job(1'b1);

        // Abort together with start in IDLE never leaves IDLE.
        bus.i_abort = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("abort_start_busy", bus.o_busy, 0);
        check("abort_start_ag_en", bus.o_ag_en, 0);
        check("abort_start_state", bus.state, IDLE);
        @(posedge clk); #1;

        for (int j = 0; j < 12; j++) begin
            run_job(AW'($urandom_range(0, 255)), (AW + 1)'($urandom_range(0, 40)),
                    $urandom_range(1, 5), 8'hFF ^ (8'h01 << $urandom_range(0, 7)),
                    $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end
        run_job(8'hFC, 9'd256, 2, 8'h7F, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
